// File: rtl/pe_dmem_arbiter_pkg.sv
// pe_dmem_arbiter_pkg
//   Shared definitions for the PE data-memory arbiter slice:
//   - arb_state_e : starvation FSM state encoding (1 bit)
//   - DEF_DMEM_ARB_STARVE_LIMIT : default blocked-cycle budget before a stall request
//   - CONFLICT_CNT_W : width of the optional conflict statistics counter
package pe_dmem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_STARVE = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_DMEM_ARB_STARVE_LIMIT = 16;
  localparam int unsigned CONFLICT_CNT_W            = 32;

endpackage

// File: rtl/pe_dmem_starve_ctr.sv
// pe_dmem_starve_ctr
//   Counts consecutive cycles in which a DMA request is blocked by PE traffic
//   and raises a registered stall request to the CP once the budget is spent.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     dma_valid_i    DMA request pending
//     pe_act_i       PE owns the bank this cycle
//     handshake_i    DMA request accepted this cycle
//     stall_req_o    registered array-issue freeze request (1 while starving)
//   STARVE_LIMIT = 0 disables stall requests entirely.
module pe_dmem_starve_ctr
  import pe_dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_DMEM_ARB_STARVE_LIMIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dma_valid_i,
  input  logic pe_act_i,
  input  logic handshake_i,
  output logic stall_req_o
);

  localparam int unsigned    CW     = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIM    = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0]  LIM_M1 = (STARVE_LIMIT > 0) ? CW'(STARVE_LIMIT - 1) : '0;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blocked;

  assign blocked = dma_valid_i & pe_act_i;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;

    if (!dma_valid_i || handshake_i) begin
      cnt_d = '0;
    end else if (blocked && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ARB_IDLE: begin
        // Enter starvation on the blocked cycle that completes the budget.
        if ((STARVE_LIMIT != 0) && blocked && (cnt_q == LIM_M1)) begin
          state_d = ARB_STARVE;
        end
      end
      ARB_STARVE: begin
        if (!dma_valid_i || handshake_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_req_o = (state_q == ARB_STARVE);

endmodule

// File: rtl/pe_dmem_arbiter.sv
// pe_dmem_arbiter
//   Shares one PE-local DMEM bank between the PE AGU/LSU port (fixed priority,
//   zero added latency) and a DMA/host port. DMA starvation is escalated to the
//   CP through oStall_Req.
//   Ports:
//     iClk, iReset             clock, synchronous active-high reset
//     iPE_*, oPE_Read_Data     PE request / load data (bank data passed through)
//     iDMA_*, oDMA_*           DMA valid/ready request and read return
//     oDMEM_*, iDMEM_Read_Data SRAM bank interface (1-cycle read latency)
//     oStall_Req               registered freeze request to CP
//   Optional: define PE_DMEM_ARB_STATS_EN to add oConflict_Count, a saturating
//   count of cycles in which DMA was blocked by PE activity.
module pe_dmem_arbiter
  import pe_dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = DEF_DMEM_ARB_STARVE_LIMIT
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iPE_Write_Enable,
  input  logic                    iPE_Read_Enable,
  input  logic [ADDR_WIDTH-1:0]   iPE_Address,
  input  logic [DATA_WIDTH/8-1:0] iPE_Byte_Select,
  input  logic [DATA_WIDTH-1:0]   iPE_Store_Data,
  output logic [DATA_WIDTH-1:0]   oPE_Read_Data,
  input  logic                    iDMA_Valid,
  input  logic                    iDMA_Write,
  input  logic [ADDR_WIDTH-1:0]   iDMA_Address,
  input  logic [DATA_WIDTH-1:0]   iDMA_Write_Data,
  output logic                    oDMA_Ready,
  output logic                    oDMA_Read_Valid,
  output logic [DATA_WIDTH-1:0]   oDMA_Read_Data,
  output logic                    oDMEM_Write_Enable,
  output logic                    oDMEM_Read_Enable,
  output logic [ADDR_WIDTH-1:0]   oDMEM_Address,
  output logic [DATA_WIDTH/8-1:0] oDMEM_Byte_Select,
  output logic [DATA_WIDTH-1:0]   oDMEM_Write_Data,
  input  logic [DATA_WIDTH-1:0]   iDMEM_Read_Data,
  output logic                    oStall_Req
`ifdef PE_DMEM_ARB_STATS_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] oConflict_Count
`endif
);

  logic pe_act;
  logic handshake;
  logic dma_rd_valid_q, dma_rd_valid_d;

  assign pe_act     = iPE_Write_Enable | iPE_Read_Enable;
  assign oDMA_Ready = ~pe_act & ~iReset;
  assign handshake  = iDMA_Valid & oDMA_Ready;

  always_comb begin
    oDMEM_Write_Enable = 1'b0;
    oDMEM_Read_Enable  = 1'b0;
    oDMEM_Address      = iPE_Address;
    oDMEM_Byte_Select  = iPE_Byte_Select;
    oDMEM_Write_Data   = iPE_Store_Data;
    if (pe_act) begin
      // Simultaneous read+write from the PE resolves to a write.
      oDMEM_Write_Enable = iPE_Write_Enable;
      oDMEM_Read_Enable  = ~iPE_Write_Enable;
    end else if (handshake) begin
      oDMEM_Write_Enable = iDMA_Write;
      oDMEM_Read_Enable  = ~iDMA_Write;
      oDMEM_Address      = iDMA_Address;
      oDMEM_Byte_Select  = '1;
      oDMEM_Write_Data   = iDMA_Write_Data;
    end
  end

  assign dma_rd_valid_d = handshake & ~iDMA_Write;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      dma_rd_valid_q <= 1'b0;
    end else begin
      dma_rd_valid_q <= dma_rd_valid_d;
    end
  end

  assign oDMA_Read_Valid = dma_rd_valid_q;
  assign oDMA_Read_Data  = iDMEM_Read_Data;
  assign oPE_Read_Data   = iDMEM_Read_Data;

  pe_dmem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i       (iClk),
    .rst_i       (iReset),
    .dma_valid_i (iDMA_Valid),
    .pe_act_i    (pe_act),
    .handshake_i (handshake),
    .stall_req_o (oStall_Req)
  );

`ifdef PE_DMEM_ARB_STATS_EN
  logic [CONFLICT_CNT_W-1:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (iDMA_Valid && pe_act && !(&conflict_q)) begin
      conflict_d = conflict_q + CONFLICT_CNT_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign oConflict_Count = conflict_q;
`endif

endmodule

// File: tb/tb_pe_dmem_arbiter.sv
module tb_pe_dmem_arbiter;

  logic        iClk;
  logic        iReset;
  logic        iPE_Write_Enable, iPE_Read_Enable;
  logic [9:0]  iPE_Address;
  logic [3:0]  iPE_Byte_Select;
  logic [31:0] iPE_Store_Data;
  logic        iDMA_Valid, iDMA_Write;
  logic [9:0]  iDMA_Address;
  logic [31:0] iDMA_Write_Data;
  logic [31:0] iDMEM_Read_Data;

  logic [31:0] oPE_Read_Data, oDMA_Read_Data, oDMEM_Write_Data;
  logic        oDMA_Ready, oDMA_Read_Valid, oDMEM_Write_Enable, oDMEM_Read_Enable, oStall_Req;
  logic [9:0]  oDMEM_Address;
  logic [3:0]  oDMEM_Byte_Select;

  logic [31:0] d0_PE_Read_Data, d0_DMA_Read_Data, d0_DMEM_Write_Data;
  logic        d0_DMA_Ready, d0_DMA_Read_Valid, d0_DMEM_Write_Enable, d0_DMEM_Read_Enable, d0_Stall_Req;
  logic [9:0]  d0_DMEM_Address;
  logic [3:0]  d0_DMEM_Byte_Select;

`ifdef PE_DMEM_ARB_STATS_EN
  logic [31:0] oConflict_Count, d0_Conflict_Count;
`endif

  int checks   = 0;
  int failures = 0;

  pe_dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .STARVE_LIMIT(4)) dut (
    .iClk(iClk), .iReset(iReset),
    .iPE_Write_Enable(iPE_Write_Enable), .iPE_Read_Enable(iPE_Read_Enable),
    .iPE_Address(iPE_Address), .iPE_Byte_Select(iPE_Byte_Select),
    .iPE_Store_Data(iPE_Store_Data), .oPE_Read_Data(oPE_Read_Data),
    .iDMA_Valid(iDMA_Valid), .iDMA_Write(iDMA_Write), .iDMA_Address(iDMA_Address),
    .iDMA_Write_Data(iDMA_Write_Data), .oDMA_Ready(oDMA_Ready),
    .oDMA_Read_Valid(oDMA_Read_Valid), .oDMA_Read_Data(oDMA_Read_Data),
    .oDMEM_Write_Enable(oDMEM_Write_Enable), .oDMEM_Read_Enable(oDMEM_Read_Enable),
    .oDMEM_Address(oDMEM_Address), .oDMEM_Byte_Select(oDMEM_Byte_Select),
    .oDMEM_Write_Data(oDMEM_Write_Data), .iDMEM_Read_Data(iDMEM_Read_Data),
    .oStall_Req(oStall_Req)
`ifdef PE_DMEM_ARB_STATS_EN
    , .oConflict_Count(oConflict_Count)
`endif
  );

  pe_dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .STARVE_LIMIT(0)) dut0 (
    .iClk(iClk), .iReset(iReset),
    .iPE_Write_Enable(iPE_Write_Enable), .iPE_Read_Enable(iPE_Read_Enable),
    .iPE_Address(iPE_Address), .iPE_Byte_Select(iPE_Byte_Select),
    .iPE_Store_Data(iPE_Store_Data), .oPE_Read_Data(d0_PE_Read_Data),
    .iDMA_Valid(iDMA_Valid), .iDMA_Write(iDMA_Write), .iDMA_Address(iDMA_Address),
    .iDMA_Write_Data(iDMA_Write_Data), .oDMA_Ready(d0_DMA_Ready),
    .oDMA_Read_Valid(d0_DMA_Read_Valid), .oDMA_Read_Data(d0_DMA_Read_Data),
    .oDMEM_Write_Enable(d0_DMEM_Write_Enable), .oDMEM_Read_Enable(d0_DMEM_Read_Enable),
    .oDMEM_Address(d0_DMEM_Address), .oDMEM_Byte_Select(d0_DMEM_Byte_Select),
    .oDMEM_Write_Data(d0_DMEM_Write_Data), .iDMEM_Read_Data(iDMEM_Read_Data),
    .oStall_Req(d0_Stall_Req)
`ifdef PE_DMEM_ARB_STATS_EN
    , .oConflict_Count(d0_Conflict_Count)
`endif
  );

  // Bank model: 1-cycle read latency, word content is a fixed function of address.
  always @(posedge iClk) begin
    if (oDMEM_Read_Enable) iDMEM_Read_Data <= 32'hA500_0000 | {22'd0, oDMEM_Address};
  end

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    iPE_Write_Enable = 1'b0; iPE_Read_Enable = 1'b0;
    iPE_Address = '0; iPE_Byte_Select = 4'h3; iPE_Store_Data = 32'h1111_2222;
    iDMA_Valid = 1'b0; iDMA_Write = 1'b0; iDMA_Address = '0; iDMA_Write_Data = '0;
  endtask

  initial begin
    idle_inputs();
    iReset = 1'b1;
    tick();
    tick();
    // Reset state
    iDMA_Valid = 1'b1; iDMA_Write = 1'b0; iDMA_Address = 10'h001;
    #1;
    chk("rst_ready", {31'd0, oDMA_Ready}, 32'd0);
    chk("rst_no_strobe", {30'd0, oDMEM_Write_Enable, oDMEM_Read_Enable}, 32'd0);
    tick();
    chk("rst_rdvalid", {31'd0, oDMA_Read_Valid}, 32'd0);
    chk("rst_stall", {31'd0, oStall_Req}, 32'd0);
    iDMA_Valid = 1'b0;
    iReset = 1'b0;
    tick();

    // 1. PE priority over a simultaneous DMA write
    iPE_Read_Enable = 1'b1; iPE_Address = 10'h010;
    iDMA_Valid = 1'b1; iDMA_Write = 1'b1; iDMA_Address = 10'h020; iDMA_Write_Data = 32'hDEAD_BEEF;
    #1;
    chk("pe_pri_re", {31'd0, oDMEM_Read_Enable}, 32'd1);
    chk("pe_pri_we", {31'd0, oDMEM_Write_Enable}, 32'd0);
    chk("pe_pri_addr", {22'd0, oDMEM_Address}, 32'h010);
    chk("pe_pri_ready", {31'd0, oDMA_Ready}, 32'd0);
    tick();
    chk("pe_rd_data", oPE_Read_Data, 32'hA500_0010);
    iPE_Read_Enable = 1'b0;
    #1;
    chk("dma_wr_we", {31'd0, oDMEM_Write_Enable}, 32'd1);
    chk("dma_wr_re", {31'd0, oDMEM_Read_Enable}, 32'd0);
    chk("dma_wr_addr", {22'd0, oDMEM_Address}, 32'h020);
    chk("dma_wr_data", oDMEM_Write_Data, 32'hDEAD_BEEF);
    chk("dma_wr_bs", {28'd0, oDMEM_Byte_Select}, 32'hF);
    chk("dma_wr_ready", {31'd0, oDMA_Ready}, 32'd1);
    tick();
    iDMA_Valid = 1'b0;
    chk("dma_wr_no_rdvalid", {31'd0, oDMA_Read_Valid}, 32'd0);

    // PE read+write together resolves to a write
    iPE_Write_Enable = 1'b1; iPE_Read_Enable = 1'b1; iPE_Address = 10'h033;
    #1;
    chk("pe_both_we", {31'd0, oDMEM_Write_Enable}, 32'd1);
    chk("pe_both_re", {31'd0, oDMEM_Read_Enable}, 32'd0);
    chk("pe_both_bs", {28'd0, oDMEM_Byte_Select}, 32'h3);
    chk("pe_both_data", oDMEM_Write_Data, 32'h1111_2222);
    tick();
    idle_inputs();
    #1;
    chk("idle_no_strobe", {30'd0, oDMEM_Write_Enable, oDMEM_Read_Enable}, 32'd0);
    tick();

    // 2. DMA read of the top word
    iDMA_Valid = 1'b1; iDMA_Write = 1'b0; iDMA_Address = 10'h3FF;
    #1;
    chk("dma_rd_ready", {31'd0, oDMA_Ready}, 32'd1);
    chk("dma_rd_re", {31'd0, oDMEM_Read_Enable}, 32'd1);
    chk("dma_rd_addr", {22'd0, oDMEM_Address}, 32'h3FF);
    tick();
    iDMA_Valid = 1'b0;
    chk("dma_rd_valid_n1", {31'd0, oDMA_Read_Valid}, 32'd1);
    chk("dma_rd_data", oDMA_Read_Data, 32'hA500_03FF);
    tick();
    chk("dma_rd_valid_n2", {31'd0, oDMA_Read_Valid}, 32'd0);

    // 3. Starvation with limit 4
    iPE_Read_Enable = 1'b1; iPE_Address = 10'h000;
    iDMA_Valid = 1'b1; iDMA_Write = 1'b0; iDMA_Address = 10'h005;
    tick(); tick(); tick();
    chk("starve_3", {31'd0, oStall_Req}, 32'd0);
    tick();
    chk("starve_4", {31'd0, oStall_Req}, 32'd1);
    chk("lim0_starve_4", {31'd0, d0_Stall_Req}, 32'd0);
    tick(); tick();
    chk("starve_6", {31'd0, oStall_Req}, 32'd1);
    chk("lim0_starve_6", {31'd0, d0_Stall_Req}, 32'd0);
    iPE_Read_Enable = 1'b0;
    #1;
    chk("starve_hs_ready", {31'd0, oDMA_Ready}, 32'd1);
    chk("starve_hs_addr", {22'd0, oDMEM_Address}, 32'h005);
    tick();
    iDMA_Valid = 1'b0;
    chk("starve_release", {31'd0, oStall_Req}, 32'd0);
    chk("starve_rdvalid", {31'd0, oDMA_Read_Valid}, 32'd1);
    chk("starve_rddata", oDMA_Read_Data, 32'hA500_0005);
    tick();

    // 4. Retract while starving
    iPE_Read_Enable = 1'b1; iDMA_Valid = 1'b1; iDMA_Address = 10'h007;
    tick(); tick(); tick(); tick();
    chk("retract_pre", {31'd0, oStall_Req}, 32'd1);
    iPE_Read_Enable = 1'b0; iDMA_Valid = 1'b0;
    #1;
    chk("retract_no_strobe", {30'd0, oDMEM_Write_Enable, oDMEM_Read_Enable}, 32'd0);
    tick();
    chk("retract_stall", {31'd0, oStall_Req}, 32'd0);
    chk("retract_no_rdvalid", {31'd0, oDMA_Read_Valid}, 32'd0);
    // Counter must have restarted from zero: three blocked cycles stay below budget
    iPE_Read_Enable = 1'b1; iDMA_Valid = 1'b1;
    tick(); tick(); tick();
    chk("retract_cnt_cleared", {31'd0, oStall_Req}, 32'd0);
    tick();
    chk("retract_restarve", {31'd0, oStall_Req}, 32'd1);

    // 5a. Reset with a stall pending and DMA still requesting
    iPE_Read_Enable = 1'b0; iReset = 1'b1;
    #1;
    chk("rstmid_ready", {31'd0, oDMA_Ready}, 32'd0);
    chk("rstmid_no_strobe", {30'd0, oDMEM_Write_Enable, oDMEM_Read_Enable}, 32'd0);
    tick();
    chk("rstmid_stall", {31'd0, oStall_Req}, 32'd0);
    chk("rstmid_rdvalid", {31'd0, oDMA_Read_Valid}, 32'd0);
    tick();
    chk("rstmid_rdvalid2", {31'd0, oDMA_Read_Valid}, 32'd0);
    iReset = 1'b0; iDMA_Valid = 1'b0;
    tick();

    // 5b. Reset the cycle after a DMA read handshake
    iDMA_Valid = 1'b1; iDMA_Address = 10'h3FF;
    tick();
    iDMA_Valid = 1'b0; iReset = 1'b1;
    chk("rstrd_return", {31'd0, oDMA_Read_Valid}, 32'd1);
    tick();
    chk("rstrd_dropped", {31'd0, oDMA_Read_Valid}, 32'd0);
    chk("rstrd_stall", {31'd0, oStall_Req}, 32'd0);
    iReset = 1'b0;
    tick();

`ifdef PE_DMEM_ARB_STATS_EN
    // 6. Conflict statistics
    chk("stats_zero", oConflict_Count, 32'd0);
    iPE_Write_Enable = 1'b1; iDMA_Valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    idle_inputs();
    chk("stats_ten", oConflict_Count, 32'd10);
    chk("lim0_stats_stall", {31'd0, d0_Stall_Req}, 32'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_dmem_arbiter.md
Name: pe_dmem_arbiter

Overview:
Shares one PE-local data-memory bank between two requesters: the PE's AGU/LSU port and a DMA/host port for bulk load/unload.
One instance sits between each pe_top DMEM port and its SRAM bank, instantiated per PE by the array generator.
The PE pipeline cannot stall locally, so the PE has fixed priority.
DMA starvation is resolved by requesting an array-wide issue freeze from the CP.

Parameters:
DATA_WIDTH, 32, data and DMA word width; byte-select width is DATA_WIDTH/8.
ADDR_WIDTH, 10, DMEM word-address width.
STARVE_LIMIT, 16, consecutive blocked DMA cycles before a stall is requested; 0 disables stall requests.

Ports:
iClk  in  1  system clock, positive-edge trigger
iReset  in  1  synchronous reset, active high
iPE_Write_Enable  in  1  PE AGU write request
iPE_Read_Enable  in  1  PE AGU read request
iPE_Address  in  ADDR_WIDTH  PE address
iPE_Byte_Select  in  DATA_WIDTH/8  PE byte lanes
iPE_Store_Data  in  DATA_WIDTH  PE store data
oPE_Read_Data  out  DATA_WIDTH  load data to PE EX stage
iDMA_Valid  in  1  DMA request valid
iDMA_Write  in  1  1=write, 0=read
iDMA_Address  in  ADDR_WIDTH  DMA address
iDMA_Write_Data  in  DATA_WIDTH  DMA write data (always full word)
oDMA_Ready  out  1  DMA request accepted this cycle
oDMA_Read_Valid  out  1  DMA read data valid
oDMA_Read_Data  out  DATA_WIDTH  DMA read data
oDMEM_Write_Enable  out  1  bank write strobe
oDMEM_Read_Enable  out  1  bank read strobe
oDMEM_Address  out  ADDR_WIDTH  bank address
oDMEM_Byte_Select  out  DATA_WIDTH/8  bank byte lanes
oDMEM_Write_Data  out  DATA_WIDTH  bank write data
iDMEM_Read_Data  in  DATA_WIDTH  bank read data, one cycle after read strobe
oStall_Req  out  1  request to CP to freeze PE-array issue

Behaviour:
- Clock and reset: single clock iClk; iReset is synchronous and active high.
- Reset values: oDMA_Read_Valid=0, oStall_Req=0, starvation counter=0, state=ARB_IDLE. Combinational outputs follow their inputs during reset, except oDMA_Ready=0.
- PE activity: pe_act = iPE_Write_Enable | iPE_Read_Enable.
  - If both are set, treat as a write and force oDMEM_Read_Enable=0.
- PE priority: when pe_act=1, the PE signals pass combinationally to the oDMEM_* outputs in the same cycle (zero added latency), and oDMA_Ready=0.
- DMA grant: oDMA_Ready = ~pe_act & ~iReset.
  - A handshake occurs when iDMA_Valid & oDMA_Ready.
  - On handshake the DMA drives oDMEM_*, with byte select all ones.
  - With no handshake and pe_act=0, all DMEM strobes are 0.
- Read return: bank latency is 1 cycle.
  - oPE_Read_Data = iDMEM_Read_Data at all times.
  - oDMA_Read_Valid is registered and set the cycle after a DMA read handshake; it is 1 for exactly one cycle per read.
  - oDMA_Read_Data = iDMEM_Read_Data.
- FSM states: ARB_IDLE, ARB_STARVE.
  - Counter behaviour:
    - Increments on cycles where iDMA_Valid & pe_act.
    - Clears on handshake or when iDMA_Valid=0.
    - Saturates at STARVE_LIMIT.
  - ARB_IDLE -> ARB_STARVE when the counter is STARVE_LIMIT-1 and still blocked (STARVE_LIMIT>0). oStall_Req is a registered output, 1 while in ARB_STARVE.
  - ARB_STARVE -> ARB_IDLE on the DMA handshake cycle; oStall_Req falls the following cycle.
  - In ARB_STARVE, the PE keeps priority while its pipeline drains; DMA waits until pe_act=0.
- iDMA_Valid dropped in ARB_STARVE: return to ARB_IDLE next cycle and clear the counter (DMA may retract).
- DMA interface rule: once asserted, iDMA_Valid and the DMA request fields hold until handshake, unless retracted.
- Reset mid-operation: any outstanding DMA read return is dropped (oDMA_Read_Valid=0 the next cycle), and a pending stall is cleared.

Optional Feature:
PE_DMEM_ARB_STATS_EN:
- Defined: adds output port oConflict_Count (32 bits), a saturating counter of cycles with iDMA_Valid & pe_act.
  - Cleared by reset.
  - Sticks at all ones.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/def-pe include gets:
  - the ARB_IDLE and ARB_STARVE state encodings (1 bit),
  - DEF_DMEM_ARB_STARVE_LIMIT default,
  - the conflict-counter width.
- One sub-module is natural: pe_dmem_starve_ctr (counter plus FSM, outputs oStall_Req). The mux and read-return tracking stay in the top.

Test Plan:
1. PE priority: PE read addr 0x010 and DMA write addr 0x020 in the same cycle -> oDMEM_Read_Enable=1, addr 0x010, oDMA_Ready=0. Next idle cycle -> DMA write addr 0x020, data 0xDEADBEEF, byte select 4'hF.
2. DMA read: idle PE, DMA read addr 0x3FF -> handshake cycle N; oDMA_Read_Valid=1 at N+1 only, with data equal to the bank model word.
3. Starvation: STARVE_LIMIT=4, PE active continuously, iDMA_Valid held.
   - oStall_Req rises after 4 blocked cycles.
   - Bench drops pe_act 2 cycles later -> handshake, and oStall_Req=0 the next cycle.
4. Retract: enter ARB_STARVE, then drop iDMA_Valid -> state ARB_IDLE and counter 0 next cycle; no DMEM strobe.
5. Reset mid-op: assert iReset the cycle after a DMA read handshake -> oDMA_Read_Valid=0, oStall_Req=0, oDMA_Ready=0 while reset is held.
6. STATS_EN: 10 conflict cycles -> oConflict_Count=10. STARVE_LIMIT=0 -> oStall_Req is never asserted.
